menu_text_renderer: RTL and testbench

- Consumer end of the config menu's text write port (write_valid/addr/data).
- Holds an 80x12 character-cell text buffer and accepts byte writes from the config state machine.
- Scans the buffer out in raster order: char code -> external font ROM -> glyph bit -> fg/bg colour, producing a pixel stream for the HDMI/video mux.
- Draws the selection pointer glyph at column 0 of the row selected by ptr_index.

---
 rtl/menu_text_pkg.sv | 40 ++++
 rtl/text_ram.sv | 30 +++
 rtl/menu_text_renderer.sv | 135 +++++++++++++
 tb/tb_menu_text_renderer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/menu_text_pkg.sv
// Shared geometry, timing and helpers for the menu text renderer.
package menu_text_pkg;

   localparam int unsigned TEXT_COLS    = 80;
   localparam int unsigned TEXT_ROWS    = 12;
   localparam int unsigned CELLS        = TEXT_COLS * TEXT_ROWS;
   localparam int unsigned CHAR_W       = 8;
   localparam int unsigned CHAR_H       = 16;
   localparam int unsigned CHAR_W_LOG2  = 3;
   localparam int unsigned CHAR_H_LOG2  = 4;
   localparam int unsigned SCALE_LOG2   = 1;
   localparam int unsigned FONT_LATENCY = 2;
   localparam logic [7:0]  PTR_GLYPH    = 8'h3E;

   // Input-to-output delay: input register, RAM read, then the font ROM.
   function automatic int unsigned calc_latency(input int unsigned font_latency);
      return 2 + font_latency;
   endfunction

   localparam int unsigned LATENCY = calc_latency(FONT_LATENCY);

   // Per-pixel side information carried alongside the character lookup.
   typedef struct packed {
      logic [2:0] gx;
      logic       in_grid;
      logic       active;
      logic       hsync;
      logic       vsync;
   } pix_tag_t;

   // row*80 + col without a multiplier: row*64 + row*16 + col.
   function automatic logic [9:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
      logic [11:0] r;
      logic [11:0] a;
      r = {7'd0, row};
      a = (r << 6) + (r << 4) + {5'd0, col};
      return a[9:0];
   endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle returns the old data.
module text_ram #(
   parameter int unsigned Depth = 1024,
   parameter int unsigned Width = 8,
   parameter int unsigned AddrW = 10
) (
   input  logic             clk_in,
   input  logic             wr_en_in,
   input  logic [AddrW-1:0] wr_addr_in,
   input  logic [Width-1:0] wr_data_in,
   input  logic [AddrW-1:0] rd_addr_in,
   output logic [Width-1:0] rd_data_out
);

   logic [Width-1:0] mem_q [Depth];

   // Write port; contents are deliberately not reset.
   always_ff @(posedge clk_in) begin
      if (wr_en_in) begin
         mem_q[wr_addr_in] <= wr_data_in;
      end
   end

   // Registered read port; sees the pre-write contents on a collision.
   always_ff @(posedge clk_in) begin
      rd_data_out <= mem_q[rd_addr_in];
   end

endmodule

// File: rtl/menu_text_renderer.sv
// Renders the 80x12 menu text buffer as an RGB888 pixel stream with a
// selection pointer drawn at column 0 of the selected row.
module menu_text_renderer
   import menu_text_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        write_valid_in,
   input  logic [9:0]  write_addr_in,
   input  logic [7:0]  write_data_in,
   input  logic [3:0]  ptr_index_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        active_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [23:0] fg_color_in,
   input  logic [23:0] bg_color_in,
   output logic [11:0] font_addr_out,
   input  logic [7:0]  font_data_in,
   output logic [23:0] pixel_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        active_out
);

   // Stages after S1 that wait on the font ROM.
   localparam int unsigned DlyDepth = LATENCY - 2;

   logic [10:0] fx;
   logic [9:0]  fy;
   logic [10:0] col_full;
   logic [9:0]  row_full;
   logic        in_grid;
   logic [9:0]  rd_addr;
   logic [7:0]  rd_data;
   logic        wr_en;

   pix_tag_t    s0_tag_d, s0_tag_q;
   logic [3:0]  gy_s0_d, gy_s0_q;
   logic [4:0]  row_s0_d, row_s0_q;
   logic        col0_s0_d, col0_s0_q;
   pix_tag_t    s1_tag_q;
   logic [11:0] font_addr_d, font_addr_q;
   pix_tag_t    dly_q [DlyDepth];
   pix_tag_t    out_tag;
   logic        ptr_hit;
   logic [7:0]  code;

   assign fx       = hcount_in >> SCALE_LOG2;
   assign fy       = vcount_in >> SCALE_LOG2;
   assign col_full = fx >> CHAR_W_LOG2;
   assign row_full = fy >> CHAR_H_LOG2;
   assign in_grid  = active_in && (col_full < 11'(TEXT_COLS)) && (row_full < 10'(TEXT_ROWS));
   // Out-of-grid addresses may alias; in_grid masks their glyph later.
   assign rd_addr  = cell_addr(row_full[4:0], col_full[6:0]);
   assign wr_en    = write_valid_in && (write_addr_in < 10'(CELLS));

   text_ram #(
      .Depth(1024),
      .Width(8),
      .AddrW(10)
   ) u_text_ram (
      .clk_in     (clk_in),
      .wr_en_in   (wr_en),
      .wr_addr_in (write_addr_in),
      .wr_data_in (write_data_in),
      .rd_addr_in (rd_addr),
      .rd_data_out(rd_data)
   );

   // S0 next-state: decompose the raster position into cell and glyph coordinates.
   always_comb begin
      s0_tag_d         = '0;
      s0_tag_d.gx      = fx[2:0];
      s0_tag_d.in_grid = in_grid;
      s0_tag_d.active  = active_in;
      s0_tag_d.hsync   = hsync_in;
      s0_tag_d.vsync   = vsync_in;
      gy_s0_d          = fy[3:0];
      row_s0_d         = row_full[4:0];
      col0_s0_d        = (col_full == 11'd0);
   end

   // S1 next-state: substitute the pointer glyph and form the font ROM address.
   always_comb begin
      ptr_hit = (ptr_index_in < 4'(TEXT_ROWS - 1)) && s0_tag_q.in_grid && col0_s0_q &&
                (row_s0_q == ({1'b0, ptr_index_in} + 5'd1));
      code        = ptr_hit ? PTR_GLYPH : rd_data;
      font_addr_d = {code, gy_s0_q};
   end

   // Pipeline registers; the tag travels in lockstep with the character lookup.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s0_tag_q    <= '0;
         gy_s0_q     <= '0;
         row_s0_q    <= '0;
         col0_s0_q   <= 1'b0;
         s1_tag_q    <= '0;
         font_addr_q <= '0;
         for (int i = 0; i < int'(DlyDepth); i++) begin
            dly_q[i] <= '0;
         end
      end else begin
         s0_tag_q    <= s0_tag_d;
         gy_s0_q     <= gy_s0_d;
         row_s0_q    <= row_s0_d;
         col0_s0_q   <= col0_s0_d;
         s1_tag_q    <= s0_tag_q;
         font_addr_q <= font_addr_d;
         dly_q[0]    <= s1_tag_q;
         for (int i = 1; i < int'(DlyDepth); i++) begin
            dly_q[i] <= dly_q[i-1];
         end
      end
   end

   assign out_tag       = dly_q[DlyDepth-1];
   assign font_addr_out = font_addr_q;
   assign hsync_out     = out_tag.hsync;
   assign vsync_out     = out_tag.vsync;
   assign active_out    = out_tag.active;

   // Output colour select; blanking follows the registered active flag, so reset
   // forces black immediately.
   always_comb begin
      pixel_out = '0;
      if (out_tag.active) begin
         pixel_out = (out_tag.in_grid && font_data_in[3'd7 - out_tag.gx]) ? fg_color_in
                                                                          : bg_color_in;
      end
   end

endmodule

// File: tb/tb_menu_text_renderer.sv
// Self-checking bench for menu_text_renderer: table vectors, a scoreboard of
// expected outputs, and hand sequences for reset, collisions and sync timing.
module tb_menu_text_renderer;
   import menu_text_pkg::*;

   localparam logic [23:0] FG = 24'hFF8000;
   localparam logic [23:0] BG = 24'h0000FF;

   logic        clk = 1'b0;
   logic        rst;
   logic        wv;
   logic [9:0]  wa;
   logic [7:0]  wd;
   logic [3:0]  ptr_index;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        active, hsync, vsync;
   logic [11:0] font_addr;
   logic [7:0]  font_data;
   logic [23:0] pixel;
   logic        hsync_o, vsync_o, active_o;

   always #5 clk = ~clk;

   menu_text_renderer dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .write_valid_in(wv),
      .write_addr_in (wa),
      .write_data_in (wd),
      .ptr_index_in  (ptr_index),
      .hcount_in     (hcount),
      .vcount_in     (vcount),
      .active_in     (active),
      .hsync_in      (hsync),
      .vsync_in      (vsync),
      .fg_color_in   (FG),
      .bg_color_in   (BG),
      .font_addr_out (font_addr),
      .font_data_in  (font_data),
      .pixel_out     (pixel),
      .hsync_out     (hsync_o),
      .vsync_out     (vsync_o),
      .active_out    (active_o)
   );

   // Font ROM model: 0x41 is a left-edge bar, 0x3E has its two left pixels set.
   function automatic logic [7:0] font_rom(input logic [7:0] code, input logic [3:0] gy);
      if (code == 8'h41) return 8'h80;
      if (code == 8'h3E) return 8'hC0;
      return code ^ {gy, 4'h0};
   endfunction

   // Two-cycle font ROM.
   logic [7:0] f1_q = 8'h00;
   logic [7:0] f2_q = 8'h00;
   always @(posedge clk) begin
      f1_q <= font_rom(font_addr[11:4], font_addr[3:0]);
      f2_q <= f1_q;
   end
   assign font_data = f2_q;

   typedef struct {
      logic [23:0] pix;
      logic        hs;
      logic        vs;
      logic        act;
      logic        fa_chk;
      logic [11:0] fa;
   } exp_t;

   typedef struct {
      logic [10:0] hc;
      logic [9:0]  vc;
      logic        act;
      logic [3:0]  ptr;
      logic [1:0]  kind;    // 0 black, 1 fg, 2 bg
      logic        fa_chk;
      logic [11:0] fa;
   } vec_t;

   exp_t       pix_q[$];
   exp_t       fa_q[$];
   logic [7:0] mem_m [CELLS];
   logic [3:0] ptr_prev = 4'hF;
   int         n_checks = 0;
   int         n_fail = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      n_checks++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, req);
      end
   endtask

   function automatic exp_t model(input logic [10:0] hc, input logic [9:0] vc,
                                  input logic act, input logic hs, input logic vs,
                                  input logic [3:0] ptr);
      int fx, fy, col, row, gx, gy;
      logic ing;
      logic [7:0] code, glyph;
      exp_t e;
      fx = int'(hc) / 2;
      fy = int'(vc) / 2;
      col = fx / 8;
      row = fy / 16;
      gx = fx % 8;
      gy = fy % 16;
      ing = act && (col < 80) && (row < 12);
      code = ing ? mem_m[row * 80 + col] : 8'h00;
      if (ing && col == 0 && ptr < 4'd11 && row == int'(ptr) + 1) code = 8'h3E;
      glyph = font_rom(code, 4'(gy));
      e.pix = !act ? 24'h0 : ((ing && glyph[7 - gx]) ? FG : BG);
      e.hs = hs;
      e.vs = vs;
      e.act = act;
      e.fa_chk = ing;
      e.fa = {code, 4'(gy)};
      return e;
   endfunction

   // One pixel clock: drive, enqueue expectations, advance, compare what has matured.
   task automatic step(input logic [10:0] hc, input logic [9:0] vc, input logic act,
                       input logic hs, input logic vs, input logic [3:0] ptr,
                       input logic we, input logic [9:0] waddr, input logic [7:0] wdata,
                       input exp_t e);
      exp_t x;
      hcount = hc;
      vcount = vc;
      active = act;
      hsync = hs;
      vsync = vs;
      // The pointer row is compared one stage after the raster is sampled.
      ptr_index = ptr_prev;
      ptr_prev = ptr;
      wv = we;
      wa = waddr;
      wd = wdata;
      pix_q.push_back(e);
      fa_q.push_back(e);
      @(posedge clk);
      #1;
      if (we && waddr < 10'd960) mem_m[waddr] = wdata;
      wv = 1'b0;
      if (fa_q.size() == 2) begin
         x = fa_q.pop_front();
         if (x.fa_chk) check("font_addr", 32'(font_addr), 32'(x.fa));
      end
      if (pix_q.size() == 4) begin
         x = pix_q.pop_front();
         check("pixel", 32'(pixel), 32'(x.pix));
         check("syncs", {29'd0, hsync_o, vsync_o, active_o}, {29'd0, x.hs, x.vs, x.act});
      end
   endtask

   task automatic mstep(input logic [10:0] hc, input logic [9:0] vc, input logic act,
                        input logic hs, input logic vs, input logic [3:0] ptr,
                        input logic we, input logic [9:0] waddr, input logic [7:0] wdata);
      step(hc, vc, act, hs, vs, ptr, we, waddr, wdata, model(hc, vc, act, hs, vs, ptr));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) mstep(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 10'd0, 8'd0);
   endtask

   task automatic check_zero(input string name);
      check({name, "_pixel"}, 32'(pixel), 32'd0);
      check({name, "_syncs"}, {29'd0, hsync_o, vsync_o, active_o}, 32'd0);
      check({name, "_font_addr"}, 32'(font_addr), 32'd0);
   endtask

   vec_t tbl[13];

   initial begin
      // Hand-derived vectors; buffer cell i holds i^0x5A except cell 85 = 0x41.
      tbl[0]  = '{hc: 11'd80,   vc: 10'd32,  act: 1'b1, ptr: 4'hF, kind: 2'd1, fa_chk: 1'b1, fa: 12'h410};
      tbl[1]  = '{hc: 11'd82,   vc: 10'd32,  act: 1'b1, ptr: 4'hF, kind: 2'd2, fa_chk: 1'b1, fa: 12'h410};
      tbl[2]  = '{hc: 11'd94,   vc: 10'd32,  act: 1'b1, ptr: 4'hF, kind: 2'd2, fa_chk: 1'b1, fa: 12'h410};
      tbl[3]  = '{hc: 11'd0,    vc: 10'd96,  act: 1'b1, ptr: 4'd2, kind: 2'd1, fa_chk: 1'b1, fa: 12'h3E0};
      tbl[4]  = '{hc: 11'd4,    vc: 10'd96,  act: 1'b1, ptr: 4'd2, kind: 2'd2, fa_chk: 1'b1, fa: 12'h3E0};
      tbl[5]  = '{hc: 11'd0,    vc: 10'd98,  act: 1'b1, ptr: 4'd2, kind: 2'd1, fa_chk: 1'b1, fa: 12'h3E1};
      tbl[6]  = '{hc: 11'd0,    vc: 10'd96,  act: 1'b1, ptr: 4'd11, kind: 2'd1, fa_chk: 1'b1, fa: 12'hAA0};
      tbl[7]  = '{hc: 11'd0,    vc: 10'd384, act: 1'b1, ptr: 4'd11, kind: 2'd2, fa_chk: 1'b0, fa: 12'h000};
      tbl[8]  = '{hc: 11'd1280, vc: 10'd32,  act: 1'b1, ptr: 4'd11, kind: 2'd2, fa_chk: 1'b0, fa: 12'h000};
      tbl[9]  = '{hc: 11'd80,   vc: 10'd32,  act: 1'b0, ptr: 4'd0, kind: 2'd0, fa_chk: 1'b0, fa: 12'h000};
      tbl[10] = '{hc: 11'd0,    vc: 10'd32,  act: 1'b1, ptr: 4'd0, kind: 2'd1, fa_chk: 1'b1, fa: 12'h3E0};
      tbl[11] = '{hc: 11'd2,    vc: 10'd0,   act: 1'b1, ptr: 4'd0, kind: 2'd1, fa_chk: 1'b1, fa: 12'h5A0};
      tbl[12] = '{hc: 11'd0,    vc: 10'd352, act: 1'b1, ptr: 4'd10, kind: 2'd1, fa_chk: 1'b1, fa: 12'h3E0};

      rst = 1'b1;
      wv = 1'b0;
      wa = '0;
      wd = '0;
      ptr_index = 4'hF;
      hcount = '0;
      vcount = '0;
      active = 1'b0;
      hsync = 1'b0;
      vsync = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Load the buffer, then place 'A' at row 1 col 5.
      for (int i = 0; i < 960; i++) begin
         mstep(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 10'(i), 8'(i) ^ 8'h5A);
      end
      mstep(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 10'd85, 8'h41);
      idle(4);

      for (int i = 0; i < 13; i++) begin
         exp_t e;
         e.pix = (tbl[i].kind == 2'd0) ? 24'h0 : ((tbl[i].kind == 2'd1) ? FG : BG);
         e.hs = 1'b0;
         e.vs = 1'b0;
         e.act = tbl[i].act;
         e.fa_chk = tbl[i].fa_chk;
         e.fa = tbl[i].fa;
         step(tbl[i].hc, tbl[i].vc, tbl[i].act, 1'b0, 1'b0, tbl[i].ptr, 1'b0, 10'd0, 8'd0, e);
      end
      idle(4);

      // Sync and active pulses must come out with the pixel they belong to.
      for (int i = 0; i < 12; i++) begin
         mstep(11'(80 + 2 * i), 10'd32, (i != 9), (i == 3), (i >= 5 && i < 8), 4'hF,
               1'b0, 10'd0, 8'd0);
      end
      idle(4);

      // Asynchronous reset between clock edges, mid-stream.
      for (int i = 0; i < 4; i++) mstep(11'd80, 10'd32, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 10'd0, 8'd0);
      check("pre_reset_active", 32'(active_o), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check_zero("async_reset");
      @(posedge clk);
      #1;
      check_zero("held_reset");
      @(negedge clk);
      rst = 1'b0;
      pix_q.delete();
      fa_q.delete();
      @(posedge clk);
      #1;

      // Out-of-range writes must not touch any cell.
      mstep(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 10'd970, 8'h99);
      mstep(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 10'd1023, 8'h77);
      for (int r = 0; r < 12; r++) begin
         for (int c = 0; c < 80; c++) begin
            mstep(11'(c * 16), 10'(r * 32), 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 10'd0, 8'd0);
         end
      end
      idle(4);

      // Write and read of the same cell in one cycle: old glyph, then new glyph.
      step(11'd80, 10'd32, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 10'd85, 8'h42,
           '{pix: FG, hs: 1'b0, vs: 1'b0, act: 1'b1, fa_chk: 1'b1, fa: 12'h410});
      step(11'd80, 10'd32, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 10'd0, 8'd0,
           '{pix: BG, hs: 1'b0, vs: 1'b0, act: 1'b1, fa_chk: 1'b1, fa: 12'h420});
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
